ahb_apb_bridge_p: RTL and testbench

Parametrised AHB-Lite slave to APB4 master bridge, the next generation of the team's fixed 32-bit AHB/APB bridge. Adds configurable address/data width and slave count, and one-hot PSEL decode over a power-of-2 address map. Also adds PREADY wait states, PSLVERR and timeout mapped to the AHB two-cycle ERROR response, and APB4 write strobes derived from Hsize and Haddr. Sits between the AHB interconnect (Hreadyin/Hreadyout handshake) and up to NUM_SLAVES APB peripherals.

---
 rtl/ahb_apb_bridge_p_pkg.sv | 40 ++++
 rtl/ahb_apb_bridge_p_if.sv | 44 ++++
 rtl/ahb_apb_bridge_p_decode.sv | 39 +++
 rtl/ahb_apb_bridge_p.sv | 185 ++++++++++++++++++
 tb/tb_ahb_apb_bridge_p.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/ahb_apb_bridge_p_pkg.sv
// Shared types for the AHB-Lite to APB4 bridge.
// Holds the AHB transfer/response encodings, the bridge state enum and the
// byte-strobe helper used when a write enters its data phase.
package ahb_apb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'd0,
        HTRANS_BUSY   = 2'd1,
        HTRANS_NONSEQ = 2'd2,
        HTRANS_SEQ    = 2'd3
    } htrans_e;

    typedef enum logic [1:0] {
        HRESP_OKAY  = 2'd0,
        HRESP_ERROR = 2'd1
    } hresp_e;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WWAIT  = 3'd1,
        SETUP  = 3'd2,
        ACCESS = 3'd3,
        ERR1   = 3'd4,
        ERR2   = 3'd5
    } bridge_state_e;

    // Byte strobes for an 8-lane bus; callers truncate to their own lane count,
    // which clips misaligned transfers at the top lane.
    function automatic logic [7:0] calc_pstrb(input logic [2:0] size, input logic [2:0] addr_lsbs);
        logic [15:0] mask;
        case (size)
            3'd0:    mask = 16'h0001;
            3'd1:    mask = 16'h0003;
            3'd2:    mask = 16'h000F;
            default: mask = 16'h00FF;
        endcase
        calc_pstrb = 8'(mask << addr_lsbs);
    endfunction

endpackage

// File: rtl/ahb_apb_bridge_p_if.sv
// Bus bundle between the AHB interconnect, the bridge and the APB slaves.
// slave  : bridge view (AHB slave in, APB master out).
// master : environment view (drives AHB requests and APB slave responses).
interface ahb_apb_bridge_p_if #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned NUM_SLAVES = 4
);
    localparam int unsigned STRB_W = DATA_W / 8;

    logic [ADDR_W-1:0]     Haddr;
    logic                  Hwrite;
    logic [1:0]            Htrans;
    logic [2:0]            Hsize;
    logic [2:0]            Hburst;
    logic [DATA_W-1:0]     Hwdata;
    logic                  Hreadyin;
    logic                  Hreadyout;
    logic [1:0]            Hresp;
    logic [DATA_W-1:0]     Hrdata;
    logic [ADDR_W-1:0]     Paddr;
    logic [NUM_SLAVES-1:0] Pselx;
    logic                  Penable;
    logic                  Pwrite;
    logic [DATA_W-1:0]     Pwdata;
    logic [STRB_W-1:0]     Pstrb;
    logic [DATA_W-1:0]     Prdata;
    logic                  Pready;
    logic                  Pslverr;

    modport slave (
        input  Haddr, Hwrite, Htrans, Hsize, Hburst, Hwdata, Hreadyin,
        input  Prdata, Pready, Pslverr,
        output Hreadyout, Hresp, Hrdata,
        output Paddr, Pselx, Penable, Pwrite, Pwdata, Pstrb
    );

    modport master (
        output Haddr, Hwrite, Htrans, Hsize, Hburst, Hwdata, Hreadyin,
        output Prdata, Pready, Pslverr,
        input  Hreadyout, Hresp, Hrdata,
        input  Paddr, Pselx, Penable, Pwrite, Pwdata, Pstrb
    );
endinterface

// File: rtl/ahb_apb_bridge_p_decode.sv
// Address/size decode for the bridge (purely combinational).
// haddr/hsize : address-phase inputs
// mapped_c    : address falls inside the APB region
// size_ok_c   : transfer size fits the data bus
// idx_c       : slave index within the region
// sel_c       : one-hot select, zero when unmapped
module ahb_apb_decode
    import ahb_apb_pkg::*;
#(
    parameter int unsigned        ADDR_W     = 32,
    parameter int unsigned        DATA_W     = 32,
    parameter int unsigned        NUM_SLAVES = 4,
    parameter logic [ADDR_W-1:0]  BASE_ADDR  = ADDR_W'(32'h8000_0000),
    parameter logic [ADDR_W-1:0]  SLV_SPAN   = ADDR_W'(32'h0001_0000),
    localparam int unsigned       IDX_W      = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1
) (
    input  logic [ADDR_W-1:0]     haddr,
    input  logic [2:0]            hsize,
    output logic                  mapped_c,
    output logic                  size_ok_c,
    output logic [IDX_W-1:0]      idx_c,
    output logic [NUM_SLAVES-1:0] sel_c
);
    localparam int unsigned       SPAN_LOG = $clog2(SLV_SPAN);
    localparam int unsigned       LANE_LOG = $clog2(DATA_W / 8);
    localparam logic [ADDR_W-1:0] REGION   = ADDR_W'(NUM_SLAVES) * SLV_SPAN;

    logic [ADDR_W-1:0] offset;

    // Offset compare avoids overflow of BASE_ADDR + REGION at the top of the map.
    always_comb begin
        offset    = haddr - BASE_ADDR;
        mapped_c  = (haddr >= BASE_ADDR) && (offset < REGION);
        size_ok_c = (hsize <= 3'(LANE_LOG));
        idx_c     = IDX_W'(offset >> SPAN_LOG);
        sel_c     = mapped_c ? (NUM_SLAVES'(1) << idx_c) : '0;
    end

endmodule

// File: rtl/ahb_apb_bridge_p.sv
// Parametrised AHB-Lite slave to APB4 master bridge.
// clock, Hreset : bridge clock, synchronous active-high reset
// bus           : AHB address/data phase signals in, Hreadyout/Hresp/Hrdata out;
//                 APB Paddr/Pselx/Penable/Pwrite/Pwdata/Pstrb out, Prdata/Pready/Pslverr in.
// Errors (unmapped, oversize, PSLVERR, wait timeout) become the two-cycle AHB ERROR.
module ahb_apb_bridge_p
    import ahb_apb_pkg::*;
#(
    parameter int unsigned       ADDR_W     = 32,
    parameter int unsigned       DATA_W     = 32,
    parameter int unsigned       NUM_SLAVES = 4,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = ADDR_W'(32'h8000_0000),
    parameter logic [ADDR_W-1:0] SLV_SPAN   = ADDR_W'(32'h0001_0000),
    parameter int unsigned       MAX_WAIT   = 16
) (
    input logic               clock,
    input logic               Hreset,
    ahb_apb_bridge_p_if.slave bus
);
    localparam int unsigned STRB_W   = DATA_W / 8;
    localparam int unsigned LANE_LOG = $clog2(STRB_W);
    localparam int unsigned IDX_W    = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    localparam int unsigned CNT_W    = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;

    bridge_state_e         state_q, state_d;
    logic                  hreadyout_q, hreadyout_d;
    logic [1:0]            hresp_q, hresp_d;
    logic [DATA_W-1:0]     hrdata_q, hrdata_d;
    logic [ADDR_W-1:0]     paddr_q, paddr_d;
    logic [NUM_SLAVES-1:0] pselx_q, pselx_d;
    logic                  penable_q, penable_d;
    logic                  pwrite_q, pwrite_d;
    logic [DATA_W-1:0]     pwdata_q, pwdata_d;
    logic [STRB_W-1:0]     pstrb_q, pstrb_d;
    logic [2:0]            hsize_q, hsize_d;
    logic [NUM_SLAVES-1:0] sel_q, sel_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;

    logic                  accept_c;
    logic                  mapped_c;
    logic                  size_ok_c;
    logic [IDX_W-1:0]      idx_c;
    logic [NUM_SLAVES-1:0] dec_sel_c;
    logic                  unused_c;

    ahb_apb_decode #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .NUM_SLAVES (NUM_SLAVES),
        .BASE_ADDR  (BASE_ADDR),
        .SLV_SPAN   (SLV_SPAN)
    ) u_decode (
        .haddr      (bus.Haddr),
        .hsize      (bus.Hsize),
        .mapped_c   (mapped_c),
        .size_ok_c  (size_ok_c),
        .idx_c      (idx_c),
        .sel_c      (dec_sel_c)
    );

    // Hburst carries no behaviour; the one-hot select already encodes the index.
    assign unused_c = ^{bus.Hburst, idx_c};

    // Next state and next values of every registered output.
    always_comb begin
        state_d  = state_q;
        hrdata_d = hrdata_q;
        paddr_d  = paddr_q;
        pwrite_d = pwrite_q;
        pwdata_d = pwdata_q;
        pstrb_d  = pstrb_q;
        hsize_d  = hsize_q;
        sel_d    = sel_q;
        cnt_d    = cnt_q;
        accept_c = hreadyout_q && bus.Hreadyin &&
                   ((bus.Htrans == HTRANS_NONSEQ) || (bus.Htrans == HTRANS_SEQ));

        case (state_q)
            IDLE, ERR2: begin
                state_d = IDLE;
                if (accept_c) begin
                    if (!mapped_c || !size_ok_c) begin
                        state_d = ERR1;
                    end else begin
                        paddr_d  = bus.Haddr;
                        pwrite_d = bus.Hwrite;
                        hsize_d  = bus.Hsize;
                        sel_d    = dec_sel_c;
                        cnt_d    = '0;
                        if (bus.Hwrite) begin
                            state_d = WWAIT;
                        end else begin
                            state_d = SETUP;
                            pstrb_d = '0;
                        end
                    end
                end
            end
            // AHB write data arrives one cycle after the address phase.
            WWAIT: begin
                pwdata_d = bus.Hwdata;
                pstrb_d  = STRB_W'(calc_pstrb(hsize_q, 3'(paddr_q[LANE_LOG-1:0])));
                state_d  = SETUP;
            end
            SETUP: begin
                state_d = ACCESS;
            end
            ACCESS: begin
                if (bus.Pready) begin
                    cnt_d = '0;
                    if (bus.Pslverr) begin
                        state_d = ERR1;
                    end else begin
                        state_d = IDLE;
                        if (!pwrite_q) begin
                            hrdata_d = bus.Prdata;
                        end
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if ((MAX_WAIT != 0) && (cnt_d == CNT_W'(MAX_WAIT))) begin
                        state_d = ERR1;
                        cnt_d   = '0;
                    end
                end
            end
            ERR1: begin
                state_d = ERR2;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Handshake and select outputs follow the state being entered.
        hreadyout_d = (state_d == IDLE) || (state_d == ERR2);
        hresp_d     = ((state_d == ERR1) || (state_d == ERR2)) ? HRESP_ERROR : HRESP_OKAY;
        pselx_d     = ((state_d == SETUP) || (state_d == ACCESS)) ? sel_d : '0;
        penable_d   = (state_d == ACCESS);
    end

    // State and output registers; reset abandons any in-flight APB access.
    always_ff @(posedge clock) begin
        if (Hreset) begin
            state_q     <= IDLE;
            hreadyout_q <= 1'b1;
            hresp_q     <= HRESP_OKAY;
            hrdata_q    <= '0;
            paddr_q     <= '0;
            pselx_q     <= '0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            pwdata_q    <= '0;
            pstrb_q     <= '0;
            hsize_q     <= '0;
            sel_q       <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            hreadyout_q <= hreadyout_d;
            hresp_q     <= hresp_d;
            hrdata_q    <= hrdata_d;
            paddr_q     <= paddr_d;
            pselx_q     <= pselx_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            pwdata_q    <= pwdata_d;
            pstrb_q     <= pstrb_d;
            hsize_q     <= hsize_d;
            sel_q       <= sel_d;
            cnt_q       <= cnt_d;
        end
    end

    assign bus.Hreadyout = hreadyout_q;
    assign bus.Hresp     = hresp_q;
    assign bus.Hrdata    = hrdata_q;
    assign bus.Paddr     = paddr_q;
    assign bus.Pselx     = pselx_q;
    assign bus.Penable   = penable_q;
    assign bus.Pwrite    = pwrite_q;
    assign bus.Pwdata    = pwdata_q;
    assign bus.Pstrb     = pstrb_q;

endmodule

// File: tb/tb_ahb_apb_bridge_p.sv
// Self-checking bench for ahb_apb_bridge_p with a transaction-level reference model.
module tb_ahb_apb_bridge_p;
    import ahb_apb_pkg::*;

    localparam int unsigned ADDR_W     = 32;
    localparam int unsigned DATA_W     = 32;
    localparam int unsigned NUM_SLAVES = 4;
    localparam int unsigned MAX_WAIT   = 16;
    localparam logic [31:0] BASE       = 32'h8000_0000;
    localparam logic [31:0] SPAN       = 32'h0001_0000;
    localparam logic [31:0] REGION     = 32'h0004_0000;

    logic clock = 1'b0;
    logic Hreset;
    always #5 clock = ~clock;

    ahb_apb_bridge_p_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_SLAVES(NUM_SLAVES)) bus ();

    ahb_apb_bridge_p #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_SLAVES(NUM_SLAVES),
        .BASE_ADDR(BASE), .SLV_SPAN(SPAN), .MAX_WAIT(MAX_WAIT)
    ) dut (
        .clock  (clock),
        .Hreset (Hreset),
        .bus    (bus)
    );

    int checks = 0;
    int errors = 0;
    logic [31:0] model_hrdata;

    // what the bench saw during one transfer
    logic [3:0]  obs_sel, obs_strb;
    logic [31:0] obs_paddr, obs_pwdata, obs_hrdata;
    logic        obs_pwrite;
    logic [1:0]  obs_hresp;
    int obs_setup, obs_psel_cycles, obs_access, obs_unstable, obs_setup_pen, obs_err_cycles, obs_done;

    // what the model predicts
    logic [3:0]  exp_sel, exp_strb;
    logic [1:0]  exp_hresp;
    int exp_setup, exp_psel_cycles, exp_access, exp_err_cycles, exp_done;

    // Transaction-level prediction: cycle counts relative to the accept edge.
    task automatic model(input logic [31:0] addr, input logic wr, input logic [2:0] size,
                         input logic [31:0] rdata, input int nwait, input logic slverr);
        bit mapped, legal, err;
        int acc;
        mapped = (addr >= BASE) && ((addr - BASE) < REGION);
        legal  = (size <= 3'd2);
        exp_strb = 4'd0;
        if (!mapped || !legal) begin
            exp_sel = 4'd0; exp_setup = -1; exp_psel_cycles = 0; exp_access = 0;
            exp_err_cycles = 2; exp_done = 2; exp_hresp = 2'd1;
        end else begin
            exp_sel   = 4'(1 << ((addr - BASE) / SPAN));
            exp_setup = wr ? 2 : 1;
            if (nwait >= int'(MAX_WAIT)) begin acc = MAX_WAIT; err = 1; end
            else begin acc = nwait + 1; err = slverr; end
            exp_access      = acc;
            exp_psel_cycles = acc + 1;
            exp_err_cycles  = err ? 2 : 0;
            exp_done        = exp_setup + acc + (err ? 2 : 1);
            exp_hresp       = err ? 2'd1 : 2'd0;
            if (wr) exp_strb = 4'((((1 << (1 << size)) - 1) << (addr % 4)));
            if (!wr && !err) model_hrdata = rdata;
        end
    endtask

    // Drives one AHB transfer from a negedge with Hreadyout=1 and plays the APB slave.
    // Returns at the negedge where Hreadyout is seen high again.
    task automatic run_xfer(input logic [31:0] addr, input logic wr, input logic [2:0] size,
                            input logic [31:0] wdata, input logic [31:0] rdata,
                            input int nwait, input logic slverr);
        int c, acc_seen;
        bit done;
        obs_sel = 0; obs_strb = 0; obs_paddr = 0; obs_pwdata = 0; obs_pwrite = 0;
        obs_setup = -1; obs_psel_cycles = 0; obs_access = 0; obs_unstable = 0;
        obs_setup_pen = 0; obs_err_cycles = 0; obs_done = -1; obs_hresp = 2'd3; obs_hrdata = 'x;
        bus.Haddr = addr; bus.Hwrite = wr; bus.Hsize = size; bus.Htrans = 2'd2;
        bus.Hreadyin = 1'b1; bus.Hburst = 3'($urandom_range(0, 7));
        bus.Pready = 1'b0; bus.Pslverr = 1'b0;
        @(negedge clock);
        bus.Htrans = 2'd0; bus.Hwdata = wdata; bus.Haddr = $urandom; bus.Hsize = 3'($urandom_range(0, 7));
        acc_seen = 0; done = 0; c = 0;
        while (!done && c < 60) begin
            c++;
            if (bus.Pselx != 0) begin
                obs_psel_cycles++;
                if (obs_setup < 0) begin
                    obs_setup = c; obs_sel = bus.Pselx; obs_paddr = bus.Paddr;
                    obs_pwrite = bus.Pwrite; obs_pwdata = bus.Pwdata; obs_strb = bus.Pstrb;
                    if (bus.Penable) obs_setup_pen++;
                end else if (bus.Paddr !== obs_paddr || bus.Pwrite !== obs_pwrite ||
                             bus.Pwdata !== obs_pwdata || bus.Pstrb !== obs_strb ||
                             bus.Pselx !== obs_sel) begin
                    obs_unstable++;
                end
            end
            if (bus.Penable && bus.Pselx == 0) obs_unstable++;
            if (bus.Penable && bus.Pselx != 0) begin
                obs_access++; acc_seen++;
                if (acc_seen > nwait) begin
                    bus.Pready = 1'b1; bus.Pslverr = slverr; bus.Prdata = rdata;
                end else begin
                    bus.Pready = 1'b0; bus.Pslverr = 1'b0; bus.Prdata = $urandom;
                end
            end else begin
                bus.Pready = 1'b0; bus.Pslverr = 1'b0;
            end
            if (bus.Hresp == 2'd1) obs_err_cycles++;
            if (bus.Hreadyout) begin
                done = 1; obs_done = c; obs_hresp = bus.Hresp; obs_hrdata = bus.Hrdata;
            end else begin
                @(negedge clock);
            end
        end
        bus.Pready = 1'b0; bus.Pslverr = 1'b0;
    endtask

    task automatic test_reset();
        Hreset = 1'b1;
        repeat (2) @(negedge clock);
        checks++; if (bus.Hreadyout !== 1'b1) begin errors++; $display("FAIL reset_hreadyout: got %b want 1", bus.Hreadyout); end
        checks++; if (bus.Hresp !== 2'd0) begin errors++; $display("FAIL reset_hresp: got %0d want 0", bus.Hresp); end
        checks++; if (bus.Hrdata !== 32'd0) begin errors++; $display("FAIL reset_hrdata: got %h want 0", bus.Hrdata); end
        checks++; if (bus.Paddr !== 32'd0 || bus.Pwdata !== 32'd0) begin errors++; $display("FAIL reset_paddr_pwdata: got %h/%h want 0/0", bus.Paddr, bus.Pwdata); end
        checks++; if ({bus.Pselx, bus.Penable, bus.Pwrite, bus.Pstrb} !== 10'd0) begin errors++; $display("FAIL reset_apb_ctrl: got sel=%b en=%b wr=%b strb=%b want all 0", bus.Pselx, bus.Penable, bus.Pwrite, bus.Pstrb); end
        Hreset = 1'b0;
        model_hrdata = 32'd0;
    endtask

    task automatic test_read_slave2();
        run_xfer(32'h8002_0010, 1'b0, 3'd2, 32'h0, 32'hDEAD_BEEF, 0, 1'b0);
        model_hrdata = 32'hDEAD_BEEF;
        checks++; if (obs_sel !== 4'b0100 || obs_setup != 1) begin errors++; $display("FAIL rd2_setup: got sel=%b at T%0d want 0100 at T1", obs_sel, obs_setup); end
        checks++; if (obs_access != 1 || obs_setup_pen != 0) begin errors++; $display("FAIL rd2_access: got %0d access cycles, setup_penable=%0d want 1/0", obs_access, obs_setup_pen); end
        checks++; if (obs_done != 3 || obs_hresp !== 2'd0) begin errors++; $display("FAIL rd2_done: got T%0d hresp=%0d want T3 hresp=0", obs_done, obs_hresp); end
        checks++; if (obs_hrdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rd2_hrdata: got %h want deadbeef", obs_hrdata); end
        checks++; if (obs_strb !== 4'd0 || obs_pwrite !== 1'b0 || obs_paddr !== 32'h8002_0010) begin errors++; $display("FAIL rd2_apb: got strb=%b wr=%b addr=%h want 0000/0/80020010", obs_strb, obs_pwrite, obs_paddr); end
    endtask

    task automatic test_byte_write();
        run_xfer(32'h8000_0003, 1'b1, 3'd0, 32'hAB00_0000, 32'h0, 0, 1'b0);
        checks++; if (obs_strb !== 4'b1000) begin errors++; $display("FAIL bw_pstrb: got %b want 1000", obs_strb); end
        checks++; if (obs_pwdata !== 32'hAB00_0000 || obs_pwrite !== 1'b1) begin errors++; $display("FAIL bw_pwdata: got %h wr=%b want ab000000 wr=1", obs_pwdata, obs_pwrite); end
        checks++; if (obs_sel !== 4'b0001 || obs_setup != 2) begin errors++; $display("FAIL bw_setup: got sel=%b T%0d want 0001 T2", obs_sel, obs_setup); end
        checks++; if (obs_done != 4 || obs_hresp !== 2'd0) begin errors++; $display("FAIL bw_done: got T%0d hresp=%0d want T4 hresp=0", obs_done, obs_hresp); end
        checks++; if (obs_hrdata !== model_hrdata) begin errors++; $display("FAIL bw_hrdata_hold: got %h want %h", obs_hrdata, model_hrdata); end
    endtask

    task automatic test_unmapped();
        run_xfer(32'h1000_0000, 1'b0, 3'd2, 32'h0, 32'h1234_5678, 0, 1'b0);
        checks++; if (obs_psel_cycles != 0) begin errors++; $display("FAIL unmap_psel: got %0d select cycles want 0", obs_psel_cycles); end
        checks++; if (obs_done != 2 || obs_err_cycles != 2 || obs_hresp !== 2'd1) begin errors++; $display("FAIL unmap_err: got done=T%0d err_cycles=%0d hresp=%0d want T2/2/1", obs_done, obs_err_cycles, obs_hresp); end
        // accepted straight out of the second error cycle
        run_xfer(32'h8001_0020, 1'b0, 3'd2, 32'h0, 32'h0BAD_F00D, 0, 1'b0);
        model_hrdata = 32'h0BAD_F00D;
        checks++; if (obs_setup != 1 || obs_sel !== 4'b0010 || obs_done != 3) begin errors++; $display("FAIL err2_accept: got sel=%b setup=T%0d done=T%0d want 0010/T1/T3", obs_sel, obs_setup, obs_done); end
        checks++; if (obs_hrdata !== 32'h0BAD_F00D) begin errors++; $display("FAIL err2_hrdata: got %h want 0badf00d", obs_hrdata); end
    endtask

    task automatic test_wait_slverr();
        run_xfer(32'h8003_0100, 1'b0, 3'd2, 32'h0, 32'hFFFF_0000, 3, 1'b1);
        checks++; if (obs_access != 4 || obs_psel_cycles != 5) begin errors++; $display("FAIL slverr_access: got %0d access %0d select cycles want 4/5", obs_access, obs_psel_cycles); end
        checks++; if (obs_done != 7 || obs_err_cycles != 2 || obs_hresp !== 2'd1) begin errors++; $display("FAIL slverr_resp: got done=T%0d err=%0d hresp=%0d want T7/2/1", obs_done, obs_err_cycles, obs_hresp); end
        checks++; if (obs_hrdata !== model_hrdata) begin errors++; $display("FAIL slverr_hrdata_hold: got %h want %h", obs_hrdata, model_hrdata); end
    endtask

    task automatic test_timeout();
        run_xfer(32'h8000_0040, 1'b1, 3'd2, 32'h5555_AAAA, 32'h0, 1000, 1'b0);
        checks++; if (obs_access != 16 || obs_psel_cycles != 17) begin errors++; $display("FAIL timeout_access: got %0d access %0d select cycles want 16/17", obs_access, obs_psel_cycles); end
        checks++; if (obs_done != 20 || obs_err_cycles != 2 || obs_hresp !== 2'd1) begin errors++; $display("FAIL timeout_resp: got done=T%0d err=%0d hresp=%0d want T20/2/1", obs_done, obs_err_cycles, obs_hresp); end
        @(negedge clock);
        checks++; if (bus.Hreadyout !== 1'b1 || bus.Hresp !== 2'd0 || bus.Pselx !== 4'd0) begin errors++; $display("FAIL timeout_idle: got rdy=%b hresp=%0d sel=%b want 1/0/0000", bus.Hreadyout, bus.Hresp, bus.Pselx); end
    endtask

    task automatic test_idle_busy();
        logic [1:0] tr [4];
        logic       rd [4];
        tr[0] = 2'd0; rd[0] = 1'b1;
        tr[1] = 2'd1; rd[1] = 1'b1;
        tr[2] = 2'd2; rd[2] = 1'b0;
        tr[3] = 2'd3; rd[3] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.Haddr = 32'h8002_0000; bus.Hwrite = 1'b0; bus.Hsize = 3'd2;
            bus.Htrans = tr[i]; bus.Hreadyin = rd[i];
            @(negedge clock);
            checks++; if (bus.Pselx !== 4'd0 || bus.Hreadyout !== 1'b1 || bus.Hresp !== 2'd0) begin errors++; $display("FAIL ignore_%0d: got sel=%b rdy=%b hresp=%0d want 0000/1/0", i, bus.Pselx, bus.Hreadyout, bus.Hresp); end
        end
        bus.Htrans = 2'd0; bus.Hreadyin = 1'b1;
    endtask

    task automatic test_random_back_to_back();
        logic [31:0] addr, wdata, rdata;
        logic [2:0]  size;
        logic        wr, slverr;
        int          nwait;
        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 9))
                0: addr = BASE - 32'($urandom_range(1, 64));
                1: addr = BASE + REGION + 32'($urandom_range(0, 64));
                2: addr = BASE;
                3: addr = BASE + REGION - 32'd1;
                default: addr = BASE + 32'($urandom_range(0, 3)) * SPAN + 32'($urandom_range(0, 32'hFFFF));
            endcase
            size = 3'($urandom_range(0, 4)); wr = 1'($urandom_range(0, 1));
            nwait = $urandom_range(0, 3); slverr = ($urandom_range(0, 5) == 0);
            wdata = $urandom; rdata = $urandom;
            model(addr, wr, size, rdata, nwait, slverr);
            run_xfer(addr, wr, size, wdata, rdata, nwait, slverr);
            checks++; if (obs_done != exp_done || obs_hresp !== exp_hresp || obs_err_cycles != exp_err_cycles) begin errors++; $display("FAIL rnd%0d_resp addr=%h: got done=T%0d hresp=%0d err=%0d want T%0d/%0d/%0d", n, addr, obs_done, obs_hresp, obs_err_cycles, exp_done, exp_hresp, exp_err_cycles); end
            checks++; if (obs_sel !== exp_sel || obs_setup != exp_setup || obs_psel_cycles != exp_psel_cycles || obs_access != exp_access) begin errors++; $display("FAIL rnd%0d_sel addr=%h: got sel=%b setup=%0d psel=%0d acc=%0d want %b/%0d/%0d/%0d", n, addr, obs_sel, obs_setup, obs_psel_cycles, obs_access, exp_sel, exp_setup, exp_psel_cycles, exp_access); end
            checks++; if (obs_unstable != 0 || obs_setup_pen != 0) begin errors++; $display("FAIL rnd%0d_stable: got unstable=%0d setup_penable=%0d want 0/0", n, obs_unstable, obs_setup_pen); end
            checks++; if (obs_hrdata !== model_hrdata) begin errors++; $display("FAIL rnd%0d_hrdata: got %h want %h", n, obs_hrdata, model_hrdata); end
            if (exp_psel_cycles != 0) begin
                checks++; if (obs_paddr !== addr || obs_pwrite !== wr || obs_strb !== exp_strb) begin errors++; $display("FAIL rnd%0d_apb: got addr=%h wr=%b strb=%b want %h/%b/%b", n, obs_paddr, obs_pwrite, obs_strb, addr, wr, exp_strb); end
                if (wr) begin
                    checks++; if (obs_pwdata !== wdata) begin errors++; $display("FAIL rnd%0d_pwdata: got %h want %h", n, obs_pwdata, wdata); end
                end
            end
        end
    endtask

    task automatic test_reset_mid_access();
        int i;
        bus.Haddr = 32'h8003_0008; bus.Hwrite = 1'b0; bus.Hsize = 3'd2;
        bus.Htrans = 2'd2; bus.Hreadyin = 1'b1; bus.Pready = 1'b0; bus.Pslverr = 1'b0;
        @(negedge clock);
        bus.Htrans = 2'd0;
        for (i = 0; i < 10; i++) begin
            if (bus.Penable === 1'b1) break;
            @(negedge clock);
        end
        checks++; if (bus.Penable !== 1'b1 || bus.Pselx !== 4'b1000) begin errors++; $display("FAIL rst_mid_reach: got en=%b sel=%b want 1/1000", bus.Penable, bus.Pselx); end
        Hreset = 1'b1;
        @(negedge clock);
        checks++; if (bus.Pselx !== 4'd0 || bus.Penable !== 1'b0 || bus.Hreadyout !== 1'b1 || bus.Hrdata !== 32'd0) begin errors++; $display("FAIL rst_mid_abort: got sel=%b en=%b rdy=%b hrdata=%h want 0000/0/1/0", bus.Pselx, bus.Penable, bus.Hreadyout, bus.Hrdata); end
        Hreset = 1'b0;
        model_hrdata = 32'd0;
        run_xfer(32'h8003_0008, 1'b0, 3'd2, 32'h0, 32'hC0DE_CAFE, 1, 1'b0);
        checks++; if (obs_done != 4 || obs_hresp !== 2'd0 || obs_hrdata !== 32'hC0DE_CAFE) begin errors++; $display("FAIL rst_mid_after: got done=T%0d hresp=%0d hrdata=%h want T4/0/c0decafe", obs_done, obs_hresp, obs_hrdata); end
    endtask

    initial begin
        Hreset = 1'b1;
        bus.Haddr = '0; bus.Hwrite = 1'b0; bus.Htrans = 2'd0; bus.Hsize = 3'd0; bus.Hburst = 3'd0;
        bus.Hwdata = '0; bus.Hreadyin = 1'b1; bus.Prdata = '0; bus.Pready = 1'b0; bus.Pslverr = 1'b0;
        model_hrdata = 32'd0;
        test_reset();
        test_read_slave2();
        test_byte_write();
        test_unmapped();
        test_wait_slverr();
        test_timeout();
        test_idle_busy();
        test_random_back_to_back();
        test_reset_mid_access();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

endmodule
